// File: rtl/eq_codec_pkg.sv
// Purpose: constants and small types shared by the codec-link transmitter and receiver.
// Latency: n/a (package only).
// Backpressure: n/a.
package eq_codec_pkg;

  localparam int CODEC_CNT_W = 10;   // frame counter width: one LRCLK period = 1024 clk
  localparam int SCLK_BIT    = 3;    // SCLK = cnt[3] -> clk/16
  localparam int MCLK_BIT    = 1;    // MCLK = cnt[1] -> clk/4
  localparam int LRCLK_BIT   = 9;    // LRCLK = cnt[9] -> clk/1024, low = left
  localparam int SLOT_W      = 24;   // audio bits per channel slot on the wire

  localparam logic [CODEC_CNT_W-1:0] RST_CNT = 10'h200;  // LRCLK high after reset

  // Slot index (one SCLK period per slot) sits between the SCLK bit and the LRCLK bit.
  localparam int SLOT_LSB   = SCLK_BIT + 1;
  localparam int SLOT_IDX_W = LRCLK_BIT - SLOT_LSB;

  typedef logic [CODEC_CNT_W-1:0] codec_cnt_t;
  typedef logic [SLOT_IDX_W-1:0]  slot_idx_t;

  function automatic slot_idx_t slot_of(input codec_cnt_t c);
    return c[LRCLK_BIT-1:SLOT_LSB];
  endfunction

endpackage

// File: rtl/codec_clk_gen.sv
// Purpose: free-running frame counter and registered MCLK/SCLK/LRCLK for the codec link.
// Latency: clock outputs track the counter bits with no skew (both updated on the same edge).
// Backpressure: none; runs unconditionally.
// Ports: clk/rst_n; cnt_nxt = counter value after the coming edge; mclk/sclk/lrclk = codec
//   clocks; frame_start / sclk_fall = high on the cycle whose closing edge starts a frame /
//   drops SCLK (counter at all-ones / low nibble all-ones).
module codec_clk_gen
  import eq_codec_pkg::*;
#(
  parameter codec_cnt_t RST_VAL = RST_CNT
) (
  input  logic       clk,
  input  logic       rst_n,
  output codec_cnt_t cnt_nxt,
  output logic       mclk,
  output logic       sclk,
  output logic       lrclk,
  output logic       frame_start,
  output logic       sclk_fall
);

  codec_cnt_t cnt;

  assign cnt_nxt     = cnt + CODEC_CNT_W'(1);
  // Strobes refer to the edge that closes the current cycle, so consumers can update
  // their own registers on exactly that edge.
  assign frame_start = &cnt;
  assign sclk_fall   = &cnt[SCLK_BIT:0];

  // Clock pins are dedicated flops loaded with the next counter bits so they stay
  // glitch-free and edge-aligned with the counter itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= RST_VAL;
      mclk  <= RST_VAL[MCLK_BIT];
      sclk  <= RST_VAL[SCLK_BIT];
      lrclk <= RST_VAL[LRCLK_BIT];
    end else begin
      cnt   <= cnt_nxt;
      mclk  <= cnt_nxt[MCLK_BIT];
      sclk  <= cnt_nxt[SCLK_BIT];
      lrclk <= cnt_nxt[LRCLK_BIT];
    end
  end

endmodule

// File: rtl/i2s_codec_tx.sv
// Purpose: I2S transmitter to the CS4272 DAC input; generates codec clocks, serializes L/R.
// Latency: a sample written with vld reaches SDin 16 clk after the next LRCLK fall (left MSB).
// Backpressure: none; smpl_req pulses once per frame, a missing sample repeats the old one
//   and sets sticky underrun.
// Ports: lft_in/rht_in/vld = sample write; smpl_req = holding regs consumed; underrun/clr_udr =
//   sticky starvation flag and its clear; MCLK/SCLK/LRCLK/SDin = codec pins.
module i2s_codec_tx #(
  parameter int DATA_W = 16,
  parameter int SLOT_W = eq_codec_pkg::SLOT_W,
  parameter logic [eq_codec_pkg::CODEC_CNT_W-1:0] RST_CNT = eq_codec_pkg::RST_CNT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] lft_in,
  input  logic [DATA_W-1:0] rht_in,
  input  logic              vld,
  output logic              smpl_req,
  output logic              underrun,
  input  logic              clr_udr,
  output logic              MCLK,
  output logic              SCLK,
  output logic              LRCLK,
  output logic              SDin
);
  import eq_codec_pkg::*;

  localparam int PAD_W = SLOT_W - DATA_W;

  codec_cnt_t cnt_nxt;
  logic       frame_start;
  logic       sclk_fall;

  codec_clk_gen #(
    .RST_VAL(RST_CNT)
  ) u_clk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt_nxt    (cnt_nxt),
    .mclk       (MCLK),
    .sclk       (SCLK),
    .lrclk      (LRCLK),
    .frame_start(frame_start),
    .sclk_fall  (sclk_fall)
  );

  logic [DATA_W-1:0] hold_lft, hold_rht;
  logic [DATA_W-1:0] shf_lft, shf_rht;
  logic              hold_full;
  logic              first_load;   // suppresses underrun on the first frame after reset

  // Bit selection for the slot being entered at the coming SCLK fall. Slot 0 is the
  // I2S one-bit delay; slots 1..SLOT_W carry the left-justified word MSB first.
  slot_idx_t         slot;
  slot_idx_t         bit_idx;
  logic              chan_rht;
  logic              in_word;
  logic [SLOT_W-1:0] word;
  logic              sd_nxt;

  assign slot     = slot_of(cnt_nxt);
  assign chan_rht = cnt_nxt[LRCLK_BIT];
  assign in_word  = (slot != '0) && (slot <= SLOT_IDX_W'(SLOT_W));
  assign bit_idx  = SLOT_IDX_W'(SLOT_W) - slot;
  assign word     = chan_rht ? (SLOT_W'(shf_rht) << PAD_W) : (SLOT_W'(shf_lft) << PAD_W);
  assign sd_nxt   = in_word & word[bit_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_lft   <= '0;
      hold_rht   <= '0;
      shf_lft    <= '0;
      shf_rht    <= '0;
      hold_full  <= 1'b0;
      first_load <= 1'b1;
      smpl_req   <= 1'b0;
      underrun   <= 1'b0;
      SDin       <= 1'b0;
    end else begin
      smpl_req <= frame_start;

      if (sclk_fall) begin
        SDin <= sd_nxt;
      end

      // Holding regs only change on vld, and every vld sets hold_full, so an empty
      // holding stage still contains the previous frame's sample: reloading it
      // repeats that sample bit-exact.
      if (frame_start) begin
        shf_lft    <= hold_lft;
        shf_rht    <= hold_rht;
        first_load <= 1'b0;
      end

      // A write on the load clk lands after the shifter has taken the old values
      // and keeps the holding stage full for the next frame.
      if (vld) begin
        hold_lft  <= lft_in;
        hold_rht  <= rht_in;
        hold_full <= 1'b1;
      end else if (frame_start) begin
        hold_full <= 1'b0;
      end

      // Set takes priority over clear.
      if (frame_start && !hold_full && !first_load) begin
        underrun <= 1'b1;
      end else if (clr_udr) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_codec_tx.sv
module tb_i2s_codec_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] lft_in, rht_in;
  logic        vld, clr_udr;
  logic        smpl_req, underrun, MCLK, SCLK, LRCLK, SDin;

  i2s_codec_tx #(
    .DATA_W (16),
    .SLOT_W (24),
    .RST_CNT(10'h200)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .lft_in  (lft_in),
    .rht_in  (rht_in),
    .vld     (vld),
    .smpl_req(smpl_req),
    .underrun(underrun),
    .clr_udr (clr_udr),
    .MCLK    (MCLK),
    .SCLK    (SCLK),
    .LRCLK   (LRCLK),
    .SDin    (SDin)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    bit          wr;    // write this sample during the frame
    bit          udr;   // expected underrun right after the load that opens the frame
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Bench timebase: position inside the 1024-clk frame, restarting at 0x200 on reset.
  logic [9:0]  tc;
  // Reference model: the sample a frame carries is the last one written before its load.
  logic [31:0] m_hold;
  logic [31:0] exp_q[$];
  // Decoded SDin, one 32-slot word per channel, bit 31 = slot 0.
  logic [31:0] capl = '0, capr = '0;
  logic [63:0] cap_q[$];
  logic [63:0] last_cap = '0;
  logic        after_rst = 1'b1;
  int          clk_err = 0, smpl_err = 0, zero_err = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tc <= 10'h200;
    else        tc <= tc + 10'd1;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_hold = '0;
      exp_q.delete();
    end else begin
      if (tc == 10'h3FF) exp_q.push_back(m_hold);
      if (vld) m_hold = {lft_in, rht_in};
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      cap_q.delete();
      after_rst = 1'b1;
    end else begin
      if ({MCLK, SCLK, LRCLK} !== {tc[1], tc[3], tc[9]}) clk_err++;
      if (smpl_req !== (tc == 10'h000)) smpl_err++;
      if (after_rst && SDin !== 1'b0) zero_err++;
      if (tc[3:0] == 4'h8) begin   // SCLK rose on the previous edge
        if (tc[9]) capr[5'd31 - tc[8:4]] = SDin;
        else       capl[5'd31 - tc[8:4]] = SDin;
      end
      if (tc == 10'h3FF) begin
        if (!after_rst) cap_q.push_back({capl, capr});
        after_rst = 1'b0;
      end
    end
  end

  function automatic logic [31:0] slot_word(input logic [15:0] s);
    return {1'b0, s, 15'b0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic wait_load(output time t);
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      if (smpl_req === 1'b1) break;
    end
    t = $time;
    chk("load_seen", 32'(smpl_req), 32'd1);
  endtask

  task automatic wait_tc(input logic [9:0] v);
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      if (tc == v) break;
    end
  endtask

  task automatic write_now(input logic [15:0] l, input logic [15:0] r);
    lft_in = l;
    rht_in = r;
    vld    = 1'b1;
    @(negedge clk);
    vld    = 1'b0;
  endtask

  task automatic write(input logic [15:0] l, input logic [15:0] r);
    @(negedge clk);
    write_now(l, r);
  endtask

  task automatic check_frames();
    logic [31:0] e;
    logic [63:0] c;
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      e = exp_q.pop_front();
      c = cap_q.pop_front();
      chk("frame_lft", c[63:32], slot_word(e[31:16]));
      chk("frame_rht", c[31:0],  slot_word(e[15:0]));
      last_cap = c;
    end
  endtask

  initial begin
    time         t_prev, t_now;
    vec_t        tab[8];
    logic [15:0] b_l, b_r;

    rst_n = 1'b0; vld = 1'b0; clr_udr = 1'b0; lft_in = '0; rht_in = '0;

    tab[0] = '{l: 16'h8001, r: 16'h7FFE, wr: 1'b1, udr: 1'b0};
    tab[1] = '{l: 16'h0000, r: 16'h0000, wr: 1'b1, udr: 1'b0};
    tab[2] = '{l: 16'h0001, r: 16'h0001, wr: 1'b1, udr: 1'b0};
    tab[3] = '{l: 16'h0002, r: 16'h0002, wr: 1'b1, udr: 1'b0};
    tab[4] = '{l: 16'h0000, r: 16'h0000, wr: 1'b0, udr: 1'b0};
    tab[5] = '{l: 16'($urandom), r: 16'($urandom), wr: 1'b1, udr: 1'b1};
    tab[6] = '{l: 16'($urandom), r: 16'($urandom), wr: 1'b1, udr: 1'b1};
    tab[7] = '{l: 16'($urandom), r: 16'($urandom), wr: 1'b1, udr: 1'b1};

    // Reset state: MCLK,SCLK,LRCLK,SDin,smpl_req,underrun = 0,0,1,0,0,0
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({MCLK, SCLK, LRCLK, SDin, smpl_req, underrun}), 32'h8);
    rst_n  = 1'b1;
    t_prev = $time;
    wait_load(t_now);
    chk("first_load_dly", 32'((t_now - t_prev) / 10), 32'd512);
    t_prev = t_now;

    for (int i = 0; i < 8; i++) begin
      chk("udr_tab", 32'(underrun), 32'(tab[i].udr));
      if (i == 2) begin
        chk("word_8001", last_cap[63:32], 32'h4000_8000);
        chk("word_7ffe", last_cap[31:0],  32'h3FFF_0000);
      end
      if (tab[i].wr) begin
        repeat ($urandom_range(900, 2)) @(negedge clk);
        write(tab[i].l, tab[i].r);
      end
      wait_load(t_now);
      chk("load_period", 32'((t_now - t_prev) / 10), 32'd1024);
      t_prev = t_now;
      check_frames();
    end

    // Sticky clear, then clear colliding with a new set.
    @(negedge clk); clr_udr = 1'b1;
    @(negedge clk); clr_udr = 1'b0;
    chk("udr_clr", 32'(underrun), 32'd0);
    wait_tc(10'h3FF);
    clr_udr = 1'b1;
    @(negedge clk); clr_udr = 1'b0;
    chk("udr_set_wins", 32'(underrun), 32'd1);
    chk("load_pulse", 32'(smpl_req), 32'd1);
    check_frames();

    // Sample B mid-frame, then A exactly on the load clk.
    @(negedge clk); clr_udr = 1'b1;
    @(negedge clk); clr_udr = 1'b0;
    b_l = 16'($urandom);
    b_r = 16'($urandom);
    repeat ($urandom_range(500, 2)) @(negedge clk);
    write(b_l, b_r);
    wait_tc(10'h3FF);
    write_now(16'h5A5A, 16'hA5A5);
    chk("load_vld_pulse", 32'(smpl_req), 32'd1);
    chk("udr_load_vld", 32'(underrun), 32'd0);
    wait_load(t_now);
    chk("udr_a_pending", 32'(underrun), 32'd0);
    check_frames();
    chk("old_sample_l", last_cap[63:32], slot_word(b_l));
    chk("old_sample_r", last_cap[31:0],  slot_word(b_r));
    wait_load(t_now);
    check_frames();
    chk("word_a_l", last_cap[63:32], 32'h2D2D_0000);
    chk("word_a_r", last_cap[31:0],  32'h52D2_8000);
    chk("udr_after_a", 32'(underrun), 32'd1);

    // Asynchronous reset inside left slot 10.
    wait_tc(10'h0A3);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_outs", 32'({MCLK, SCLK, LRCLK, SDin, smpl_req, underrun}), 32'h8);
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    t_prev = $time;
    b_l = 16'($urandom);
    b_r = 16'($urandom);
    repeat ($urandom_range(400, 2)) @(negedge clk);
    write(b_l, b_r);
    wait_load(t_now);
    chk("rst_load_dly", 32'((t_now - t_prev) / 10), 32'd512);
    chk("rst_udr_suppr", 32'(underrun), 32'd0);
    wait_load(t_now);
    check_frames();
    chk("rst_data_l", last_cap[63:32], slot_word(b_l));
    chk("rst_data_r", last_cap[31:0],  slot_word(b_r));

    chk("clk_outputs", 32'(clk_err), 32'd0);
    chk("smpl_req_timing", 32'(smpl_err), 32'd0);
    chk("sdin_zero_after_rst", 32'(zero_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
